// File: rtl/ascii_pkg.sv
// ascii_pkg: shared constants, types and byte classifiers for the ASCII
// character gate (letter ranges, DEL, case bit, word FSM states, FIFO entry).
package ascii_pkg;

    localparam logic [7:0] UPPER_LO  = 8'h41;
    localparam logic [7:0] UPPER_HI  = 8'h5A;
    localparam logic [7:0] LOWER_LO  = 8'h61;
    localparam logic [7:0] LOWER_HI  = 8'h7A;
    localparam logic [7:0] CTRL_HI   = 8'h1F;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    // Bit that differs between the upper- and lower-case form of a letter.
    localparam int CASE_BIT = 5;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_WORD = 1'b1
    } word_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       is_letter;
        logic       word_start;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic byte_is_letter(input logic [7:0] b);
        return ((b >= UPPER_LO) && (b <= UPPER_HI)) ||
               ((b >= LOWER_LO) && (b <= LOWER_HI));
    endfunction

    function automatic logic byte_is_ctrl(input logic [7:0] b);
        return (b <= CTRL_HI) || (b == ASCII_DEL);
    endfunction

endpackage

// File: rtl/ascii_fifo.sv
// ascii_fifo: synchronous FIFO, DEPTH entries of WIDTH bits, extra pointer
// bit distinguishes full from empty.
// Ports: clk, rst (sync, active-high), push_i/wdata_i write side,
//        pop_i/rdata_o read side, full_o, empty_o status.
//        rdata_o reads as zero while the FIFO is empty.
module ascii_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    // Same slot, different lap: writer is one full pass ahead.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ascii_char_gate.sv
// ascii_char_gate: classifies incoming ASCII bytes (letter / word start),
// counts letters and buffers them in a small FIFO for a case-converter.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data/out_is_letter/out_word_start
//        downstream; letter_cnt saturating letter count.
// Option: define ASCII_GATE_DROP_CTRL_EN to swallow control bytes
//        (0x00-0x1F, 0x7F) instead of forwarding them.
module ascii_char_gate
    import ascii_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_is_letter,
    output logic             out_word_start,
    output logic [CNT_W-1:0] letter_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    word_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fifo_entry_t      wentry;
    fifo_entry_t      head;
    logic [ENTRY_W-1:0] head_raw;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             accept;
    logic             in_letter;

    // in_ready depends only on registered state and rst, never on out_ready.
    assign in_ready  = !full && !rst;
    assign accept    = in_valid && in_ready;
    assign in_letter = byte_is_letter(in_data);

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        wentry  = '0;
        if (accept) begin
            wentry.data      = in_data;
            wentry.is_letter = in_letter;
            push             = 1'b1;
`ifdef ASCII_GATE_DROP_CTRL_EN
            // Dropped bytes still break a word.
            if (byte_is_ctrl(in_data)) begin
                push = 1'b0;
            end
`endif
            case (state_q)
                ST_GAP: begin
                    if (in_letter) begin
                        state_d           = ST_WORD;
                        wentry.word_start = 1'b1;
                    end
                end
                ST_WORD: begin
                    if (!in_letter) begin
                        state_d = ST_GAP;
                    end
                end
                default: begin
                    state_d = ST_GAP;
                end
            endcase
            if (in_letter && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    ascii_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head           = fifo_entry_t'(head_raw);
    assign out_data       = head.data;
    assign out_is_letter  = head.is_letter;
    assign out_word_start = head.word_start;
    assign letter_cnt     = cnt_q;

endmodule
